// File: rtl/alu_seq16_pkg.sv
// Shared types and constants for the 16-bit sequencer in front of the 8-bit ALU.
package alu_seq16_pkg;

  typedef enum logic [1:0] {
    SQ_ADD16 = 2'd0,
    SQ_SUB16 = 2'd1,
    SQ_XOR16 = 2'd2,
    SQ_SHL16 = 2'd3
  } sq_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } sq_state_t;

  typedef enum logic [2:0] {
    ASEL_ZERO,
    ASEL_A_LO,
    ASEL_A_HI,
    ASEL_R_LO,
    ASEL_R_HI
  } a_sel_t;

  typedef enum logic [2:0] {
    BSEL_ZERO,
    BSEL_B_LO,
    BSEL_B_HI,
    BSEL_A_LO,
    BSEL_A_HI,
    BSEL_C
  } b_sel_t;

  localparam logic [2:0] SQ_STEPS_ARITH = 3'd4;
  localparam logic [2:0] SQ_STEPS_LOGIC = 3'd2;

endpackage

// File: rtl/definitionsABC.sv
// Opcode encoding of the shared 8-bit combinational ALU.
// Every block that drives the ALU takes its opcodes from here.
package definitionsABC;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t kADDL = 4'h0;
  localparam alu_op_t kSUB  = 4'h1;
  localparam alu_op_t kAND  = 4'h2;
  localparam alu_op_t kOR   = 4'h3;
  localparam alu_op_t kXOR  = 4'h4;
  localparam alu_op_t kBL   = 4'h8;
  localparam alu_op_t kBE   = 4'h9;
  localparam alu_op_t kSLG  = 4'hA;
  localparam alu_op_t kSLO  = 4'hB;
  localparam alu_op_t kSRG  = 4'hC;

endpackage

// File: rtl/alu_seq16_ucode.sv
// Micro-sequence table: maps (request op, step) to the ALU opcode,
// operand/shift-in selects and the capture enables for that step.
module alu_seq16_ucode
  import definitionsABC::*;
  import alu_seq16_pkg::*;
(
  input  sq_op_t      op,
  input  logic [1:0]  step,
  output alu_op_t     alu_op,
  output a_sel_t      a_sel,
  output b_sel_t      b_sel,
  output logic        sc_from_c,
  output logic        cap_lo,
  output logic        cap_hi,
  output logic        cap_c_br,
  output logic        cap_c_sc
);

  always_comb begin
    alu_op    = kADDL;
    a_sel     = ASEL_ZERO;
    b_sel     = BSEL_ZERO;
    sc_from_c = 1'b0;
    cap_lo    = 1'b0;
    cap_hi    = 1'b0;
    cap_c_br  = 1'b0;
    cap_c_sc  = 1'b0;
    case (op)
      SQ_ADD16, SQ_SUB16: begin
        case (step)
          2'd0: begin
            alu_op = (op == SQ_ADD16) ? kADDL : kSUB;
            a_sel  = ASEL_A_LO;
            b_sel  = BSEL_B_LO;
            cap_lo = 1'b1;
          end
          2'd1: begin
            // Carry of the low add is R_lo < A_lo; borrow of the low sub is A_lo < B_lo.
            alu_op   = kBL;
            a_sel    = (op == SQ_ADD16) ? ASEL_R_LO : ASEL_A_LO;
            b_sel    = (op == SQ_ADD16) ? BSEL_A_LO : BSEL_B_LO;
            cap_c_br = 1'b1;
          end
          2'd2: begin
            alu_op = (op == SQ_ADD16) ? kADDL : kSUB;
            a_sel  = ASEL_A_HI;
            b_sel  = BSEL_B_HI;
            cap_hi = 1'b1;
          end
          default: begin
            alu_op = (op == SQ_ADD16) ? kADDL : kSUB;
            a_sel  = ASEL_R_HI;
            b_sel  = BSEL_C;
            cap_hi = 1'b1;
          end
        endcase
      end
      SQ_XOR16: begin
        alu_op = kXOR;
        if (step == 2'd0) begin
          a_sel  = ASEL_A_LO;
          b_sel  = BSEL_B_LO;
          cap_lo = 1'b1;
        end else if (step == 2'd1) begin
          a_sel  = ASEL_A_HI;
          b_sel  = BSEL_B_HI;
          cap_hi = 1'b1;
        end
      end
      default: begin
        if (step == 2'd0) begin
          alu_op   = kSLG;
          b_sel    = BSEL_A_LO;
          cap_lo   = 1'b1;
          cap_c_sc = 1'b1;
        end else if (step == 2'd1) begin
          alu_op    = kSLO;
          b_sel     = BSEL_A_HI;
          sc_from_c = 1'b1;
          cap_hi    = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/alu_seq16.sv
// 16-bit operation sequencer: runs one accepted request as a chain of 8-bit
// ALU steps and returns the 16-bit result with a one-cycle strobe.
module alu_seq16
  import definitionsABC::*;
  import alu_seq16_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [1:0]  REQ_OP,
  input  logic [15:0] REQ_A,
  input  logic [15:0] REQ_B,
  output logic [3:0]  ALU_OP,
  output logic [7:0]  ALU_A,
  output logic [7:0]  ALU_B,
  output logic        ALU_SC_IN,
  input  logic [7:0]  ALU_OUT,
  input  logic        ALU_SC_OUT,
  input  logic        ALU_BR_FLAG,
  output logic        RES_VALID,
  output logic [15:0] RES_DATA
);

  sq_state_t   state;
  sq_op_t      op_q;
  logic [15:0] a_q, b_q;
  logic [1:0]  step_cnt;
  logic [7:0]  r_lo, r_hi;
  logic        c_q;

  alu_op_t     uc_op;
  a_sel_t      a_sel;
  b_sel_t      b_sel;
  logic        sc_from_c, cap_lo, cap_hi, cap_c_br, cap_c_sc;

  logic        in_step, last_step;
  logic [2:0]  n_steps;
  logic [7:0]  r_lo_nxt, r_hi_nxt;
  logic        c_nxt;

  alu_seq16_ucode u_ucode (
    .op        (op_q),
    .step      (step_cnt),
    .alu_op    (uc_op),
    .a_sel     (a_sel),
    .b_sel     (b_sel),
    .sc_from_c (sc_from_c),
    .cap_lo    (cap_lo),
    .cap_hi    (cap_hi),
    .cap_c_br  (cap_c_br),
    .cap_c_sc  (cap_c_sc)
  );

  always_comb begin
    in_step   = (state == STEP);
    n_steps   = (op_q == SQ_ADD16 || op_q == SQ_SUB16) ? SQ_STEPS_ARITH : SQ_STEPS_LOGIC;
    last_step = ({1'b0, step_cnt} == n_steps - 3'd1);
    r_lo_nxt  = (in_step && cap_lo) ? ALU_OUT : r_lo;
    r_hi_nxt  = (in_step && cap_hi) ? ALU_OUT : r_hi;
    c_nxt     = (in_step && cap_c_br) ? ALU_BR_FLAG :
                (in_step && cap_c_sc) ? ALU_SC_OUT  : c_q;
  end

  // ALU drive: idle values outside STEP, otherwise the registered operands.
  always_comb begin
    ALU_OP    = kADDL;
    ALU_A     = 8'h00;
    ALU_B     = 8'h00;
    ALU_SC_IN = 1'b0;
    if (in_step) begin
      ALU_OP    = uc_op;
      ALU_SC_IN = sc_from_c & c_q;
      case (a_sel)
        ASEL_A_LO: ALU_A = a_q[7:0];
        ASEL_A_HI: ALU_A = a_q[15:8];
        ASEL_R_LO: ALU_A = r_lo;
        ASEL_R_HI: ALU_A = r_hi;
        default:   ALU_A = 8'h00;
      endcase
      case (b_sel)
        BSEL_B_LO: ALU_B = b_q[7:0];
        BSEL_B_HI: ALU_B = b_q[15:8];
        BSEL_A_LO: ALU_B = a_q[7:0];
        BSEL_A_HI: ALU_B = a_q[15:8];
        BSEL_C:    ALU_B = {7'b0, c_q};
        default:   ALU_B = 8'h00;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      REQ_READY <= 1'b1;
      RES_VALID <= 1'b0;
      RES_DATA  <= 16'h0000;
      op_q      <= SQ_ADD16;
      a_q       <= 16'h0000;
      b_q       <= 16'h0000;
      step_cnt  <= 2'd0;
      r_lo      <= 8'h00;
      r_hi      <= 8'h00;
      c_q       <= 1'b0;
    end else begin
      r_lo      <= r_lo_nxt;
      r_hi      <= r_hi_nxt;
      c_q       <= c_nxt;
      RES_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ_VALID) begin
            op_q      <= sq_op_t'(REQ_OP);
            a_q       <= REQ_A;
            b_q       <= REQ_B;
            step_cnt  <= 2'd0;
            state     <= STEP;
            REQ_READY <= 1'b0;
          end
        end
        STEP: begin
          // The last step's capture lands on this same edge, so publish the next-values.
          if (last_step) begin
            state     <= DONE;
            RES_VALID <= 1'b1;
            RES_DATA  <= {r_hi_nxt, r_lo_nxt};
          end else begin
            step_cnt <= step_cnt + 2'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          REQ_READY <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          REQ_READY <= 1'b1;
          step_cnt  <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_seq16.md
# alu_seq16

16-bit operation sequencer in front of the shared 8-bit combinational ALU. It accepts one 16-bit request at a time over a valid/ready handshake and runs it as a fixed micro-sequence of one ALU step per cycle. It drives the ALU opcode, operands and shift-in, and registers the ALU outputs after each step. When the sequence ends it returns the 16-bit result with a one-cycle valid pulse.

## Interface
- Parameters: none. Widths are fixed: 8-bit ALU, 16-bit operands.
- CLK  in  1  system clock; all state updates on the rising edge
- RESET_N  in  1  reset, asynchronous, active-low
- REQ_VALID  in  1  request present
- REQ_READY  out  1  high only in IDLE; a request is accepted on an edge where REQ_VALID & REQ_READY
- REQ_OP  in  2  request opcode: 0 ADD16, 1 SUB16, 2 XOR16, 3 SHL16
- REQ_A, REQ_B  in  16 each  operands; REQ_B is ignored for SHL16
- ALU_OP  out  4  opcode to the ALU (definitionsABC encoding)
- ALU_A, ALU_B  out  8 each  ALU operands
- ALU_SC_IN  out  1  ALU shift-in
- ALU_OUT  in  8  ALU result
- ALU_SC_OUT  in  1  ALU shift/carry out
- ALU_BR_FLAG  in  1  ALU compare flag
- RES_VALID  out  1  one-cycle result strobe
- RES_DATA  out  16  result; holds until the next result

## Operation
- On accept, register REQ_OP, REQ_A and REQ_B; step counter := 0. Only registered copies drive the ALU.
- State machine: IDLE -> STEP (counter 0..N-1) -> DONE -> IDLE.
  - N = 4 for ADD16/SUB16, N = 2 for XOR16/SHL16.
  - DONE lasts exactly one cycle.
- Internal state: result registers R_lo, R_hi; carry/borrow bit C. Each STEP cycle's ALU outputs are captured at that cycle's closing edge.
- ADD16:
  - s0: kADDL(A_lo, B_lo) -> R_lo
  - s1: kBL(R_lo, A_lo) -> C = ALU_BR_FLAG (unsigned carry)
  - s2: kADDL(A_hi, B_hi) -> R_hi
  - s3: kADDL(R_hi, {7'b0,C}) -> R_hi
- SUB16:
  - s0: kSUB(A_lo, B_lo) -> R_lo
  - s1: kBL(A_lo, B_lo) -> C (borrow)
  - s2: kSUB(A_hi, B_hi) -> R_hi
  - s3: kSUB(R_hi, {7'b0,C}) -> R_hi
- XOR16:
  - s0: kXOR(A_lo, B_lo) -> R_lo
  - s1: kXOR(A_hi, B_hi) -> R_hi
- SHL16 (shifted operand on ALU_B, ALU_A = 0):
  - s0: kSLG(B = A_lo) -> R_lo, C = ALU_SC_OUT
  - s1: kSLO(B = A_hi, ALU_SC_IN = C) -> R_hi
- Arithmetic is modulo 2^16. No carry-out or overflow is reported. SHL16 drops bit 15.
- ALU_SC_OUT is used only in SHL16 s0. ALU_BR_FLAG is used only in s1 of ADD16/SUB16.
- Outside STEP, drive ALU_OP = kADDL, ALU_A = ALU_B = 0, ALU_SC_IN = 0. ALU_SC_IN is 0 in every step except SHL16 s1.
- Entering DONE: RES_DATA := {R_hi, R_lo} and RES_VALID = 1 for that cycle.

## Timing
- The request is accepted at edge T. Steps occupy cycles T+1 .. T+N.
- RES_VALID is high in cycle T+N+1. Latency is 5 cycles for ADD16/SUB16 and 3 cycles for XOR16/SHL16.
- REQ_READY is low from T+1 through DONE and high again the cycle after DONE. Minimum request spacing is N+2 cycles.
- REQ_VALID asserted while busy is ignored. The requester must hold REQ_VALID and its operands until the accept edge. Operand changes after accept have no effect.
- Reset values: REQ_READY = 1 (IDLE), RES_VALID = 0, RES_DATA = 0, C = 0, R_lo = R_hi = 0, counter = 0, ALU outputs at their idle values.
- Reset asserted mid-sequence immediately forces IDLE. The in-flight request is discarded, no RES_VALID is produced, and RES_DATA = 0.
- An invalid or unknown state recovers to IDLE.

## Structure
- Shared package:
  - request opcode enum (SQ_ADD16, SQ_SUB16, SQ_XOR16, SQ_SHL16)
  - FSM state enum (IDLE, STEP, DONE)
  - step-count constants (4 and 2)
- ALU opcodes come from the existing definitionsABC package and are never re-encoded.
- One sub-module is natural: alu_seq16_ucode. It is a combinational map from (op, step) to ALU opcode, A-select, B-select, SC_IN-select and capture enables.
- The top module holds the FSM, counter, operand, result and carry registers.

## Test plan
- ADD16 0x12FF + 0x0001 -> RES_DATA 0x1300, RES_VALID exactly 5 cycles after accept. Also 0xFFFF + 0x0001 -> 0x0000.
- SUB16 0x1000 - 0x0001 -> 0x0FFF. SUB16 0x0000 - 0x0001 -> 0xFFFF. Each RES_VALID is a single-cycle pulse.
- SHL16 0x80C0 -> 0x0180, latency 3. Check that ALU_SC_IN = 1 during step s1.
- XOR16 0xA5A5 ^ 0x0FF0 -> 0xAA55. Then issue a back-to-back XOR16 with REQ_VALID held continuously: the second is accepted exactly on the cycle REQ_READY returns high.
- REQ_VALID and operands toggled during an ADD16 in flight -> ignored. The result reflects the accepted operands only.
- RESET_N pulsed low during step s2 of ADD16:
  - REQ_READY is 1 immediately and RES_DATA = 0.
  - No RES_VALID pulse follows.
  - A new SUB16 issued after release completes correctly.
